// File: rtl/noc_pkg.sv
// noc_pkg
//   Shared definitions for the NoC router output side: output-port index
//   constants, the port count and the credit-tracker FSM state encoding.
//   No ports; imported with `import noc_pkg::*;`.
package noc_pkg;

   localparam int NUM_PORTS  = 5;

   localparam int PORT_NORTH = 0;
   localparam int PORT_SOUTH = 1;
   localparam int PORT_EAST  = 2;
   localparam int PORT_WEST  = 3;
   localparam int PORT_LOCAL = 4;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } credit_state_e;

endpackage

// File: rtl/credit_counter.sv
// credit_counter
//   One saturating up/down credit counter for a single output port.
//   Ports:
//     clk        in   clock
//     rst        in   synchronous active-high reset (loads BUF_DEPTH)
//     load       in   reload BUF_DEPTH (start-up)
//     freeze     in   hold the current count
//     sent       in   one flit forwarded this cycle (consumes a credit)
//     ret        in   one credit returned this cycle
//     cnt        out  current credit count, 0..BUF_DEPTH
//     underflow  out  send with no credit and no simultaneous return
//     overflow   out  return at full count with no simultaneous send
//     has_credit out  cnt != 0
module credit_counter #(
   parameter int BUF_DEPTH = 4,
   parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             freeze,
   input  logic             sent,
   input  logic             ret,
   output logic [CNT_W-1:0] cnt,
   output logic             underflow,
   output logic             overflow,
   output logic             has_credit
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] ZERO = '0;

   logic empty;
   logic full;

   assign empty      = (cnt == ZERO);
   assign full       = (cnt == FULL);
   assign has_credit = ~empty;

   // Violation flags: a simultaneous send and return always nets to zero and is legal.
   always_comb begin
      underflow = sent & ~ret & empty;
      overflow  = ret & ~sent & full;
   end

   // Counter register: reload, freeze, or saturating +/-1.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         cnt <= FULL;
      end else if (freeze) begin
         cnt <= cnt;
      end else if (sent && !ret && !empty) begin
         cnt <= cnt - ONE;
      end else if (ret && !sent && !full) begin
         cnt <= cnt + ONE;
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/credit_ctrl.sv
// credit_ctrl
//   Per-output-port credit tracker. Produces the credit_en qualifiers the
//   flow control unit ANDs with pending requests. Sequences INIT -> RUN and
//   locks into ERR on any credit underflow/overflow until rst.
//   Optional feature macro: CREDIT_BYPASS_EN -- in RUN a same-cycle returned
//   credit makes credit_en_o[p] high even when the count is 0.
//   Ports:
//     clk           in   clock
//     rst           in   synchronous active-high reset
//     flit_sent_i   in   per port: a flit left this output this cycle
//     credit_ret_i  in   per port: downstream freed one slot this cycle
//     credit_en_o   out  per port: credit available (gated by state)
//     credit_cnt_o  out  flattened counters, port p at [p*CNT_W +: CNT_W]
//     err_o         out  sticky credit protocol error
//     err_port_o    out  lowest-index port that violated first
module credit_ctrl
   import noc_pkg::*;
#(
   parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
   parameter int BUF_DEPTH = 4,
   parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PORTS-1:0]       flit_sent_i,
   input  logic [NUM_PORTS-1:0]       credit_ret_i,
   output logic [NUM_PORTS-1:0]       credit_en_o,
   output logic [NUM_PORTS*CNT_W-1:0] credit_cnt_o,
   output logic                       err_o,
   output logic [2:0]                 err_port_o
);

   credit_state_e        state;
   logic                 in_run;
   logic [NUM_PORTS-1:0] underflow;
   logic [NUM_PORTS-1:0] overflow;
   logic [NUM_PORTS-1:0] has_credit;
   logic [NUM_PORTS-1:0] viol;
   logic [2:0]           first_port;

   assign in_run = (state == RUN);

   for (genvar p = 0; p < NUM_PORTS; p++) begin : gen_port
      credit_counter #(
         .BUF_DEPTH (BUF_DEPTH),
         .CNT_W     (CNT_W)
      ) u_counter (
         .clk        (clk),
         .rst        (rst),
         .load       (state == INIT),
         .freeze     (!in_run),
         .sent       (flit_sent_i[p]),
         .ret        (credit_ret_i[p]),
         .cnt        (credit_cnt_o[p*CNT_W +: CNT_W]),
         .underflow  (underflow[p]),
         .overflow   (overflow[p]),
         .has_credit (has_credit[p])
      );
   end

   // Violations only count while counters are live.
   always_comb begin
      if (in_run) begin
         viol = underflow | overflow;
      end else begin
         viol = '0;
      end
   end

   // Lowest-index priority encoder: scan high to low so the lowest set bit wins.
   always_comb begin
      first_port = 3'd0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (viol[i]) begin
            first_port = 3'(i);
         end else begin
            first_port = first_port;
         end
      end
   end

   // Credit enable decode; only the bypass build looks at live inputs.
   always_comb begin
      if (in_run) begin
`ifdef CREDIT_BYPASS_EN
         credit_en_o = has_credit | credit_ret_i;
`else
         credit_en_o = has_credit;
`endif
      end else begin
         credit_en_o = '0;
      end
   end

   // Start-up / error FSM with registered error outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= INIT;
         err_o      <= 1'b0;
         err_port_o <= 3'd0;
      end else begin
         case (state)
            INIT: begin
               state <= RUN;
            end
            RUN: begin
               if (|viol) begin
                  state      <= ERR;
                  err_o      <= 1'b1;
                  err_port_o <= first_port;
               end else begin
                  state <= RUN;
               end
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_credit_ctrl.sv
// tb_credit_ctrl
//   Directed self-checking bench for credit_ctrl (NUM_PORTS=5, BUF_DEPTH=4),
//   followed by legal random traffic compared against a count model.
module tb_credit_ctrl;

   localparam int NP    = 5;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic            clk;
   logic            rst;
   logic [NP-1:0]   flit_sent;
   logic [NP-1:0]   credit_ret;
   logic [NP-1:0]   credit_en;
   logic [NP*CW-1:0] credit_cnt;
   logic            err;
   logic [2:0]      err_port;

   int n_vec;
   int n_err;
   int m [NP];

   credit_ctrl #(
      .NUM_PORTS (NP),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flit_sent_i  (flit_sent),
      .credit_ret_i (credit_ret),
      .credit_en_o  (credit_en),
      .credit_cnt_o (credit_cnt),
      .err_o        (err),
      .err_port_o   (err_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NP*CW-1:0] pack(input int c0, input int c1, input int c2,
                                             input int c3, input int c4);
      logic [NP*CW-1:0] v;
      v = {3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
      return v;
   endfunction

   function automatic logic [NP*CW-1:0] pack_model();
      logic [NP*CW-1:0] v;
      v = '0;
      for (int p = 0; p < NP; p++) v[p*CW +: CW] = 3'(m[p]);
      return v;
   endfunction

   function automatic logic [NP-1:0] en_model();
      logic [NP-1:0] v;
      v = '0;
      for (int p = 0; p < NP; p++) v[p] = (m[p] != 0);
      return v;
   endfunction

   // Drive one cycle of inputs, then return to idle inputs just after the edge.
   task automatic cycle(input logic [NP-1:0] s, input logic [NP-1:0] r);
      flit_sent  = s;
      credit_ret = r;
      @(posedge clk);
      #1;
      flit_sent  = '0;
      credit_ret = '0;
      #1;
   endtask

   initial begin
      logic [NP-1:0] s;
      logic [NP-1:0] r;
      logic [1:0]    pick;
      logic          exp_byp;

      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b1;
      flit_sent  = '0;
      credit_ret = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_en",   32'(credit_en),  32'h0);
      check("rst_cnt",  32'(credit_cnt), 32'(pack(4, 4, 4, 4, 4)));
      check("rst_err",  32'(err),        32'h0);
      check("rst_port", 32'(err_port),   32'h0);

      // First cycle after release is INIT with enables low.
      rst = 1'b0;
      #1;
      check("init_en", 32'(credit_en), 32'h0);
      cycle(5'b00000, 5'b00000);
      check("run_en",  32'(credit_en),  32'h1f);
      check("run_cnt", 32'(credit_cnt), 32'(pack(4, 4, 4, 4, 4)));

      // Drain port 0: 3,2,1,0.
      cycle(5'b00001, 5'b00000);
      check("p0_cnt3", 32'(credit_cnt), 32'(pack(3, 4, 4, 4, 4)));
      cycle(5'b00001, 5'b00000);
      check("p0_cnt2", 32'(credit_cnt), 32'(pack(2, 4, 4, 4, 4)));
      cycle(5'b00001, 5'b00000);
      check("p0_cnt1", 32'(credit_cnt), 32'(pack(1, 4, 4, 4, 4)));
      check("p0_en1",  32'(credit_en),  32'h1f);
      cycle(5'b00001, 5'b00000);
      check("p0_cnt0", 32'(credit_cnt), 32'(pack(0, 4, 4, 4, 4)));
      check("p0_en0",  32'(credit_en),  32'h1e);
      check("p0_err",  32'(err),        32'h0);
      cycle(5'b00000, 5'b00001);
      check("p0_ret_cnt", 32'(credit_cnt), 32'(pack(1, 4, 4, 4, 4)));
      check("p0_ret_en",  32'(credit_en),  32'h1f);

      // Drain port 2, then send+return together at zero.
      repeat (4) cycle(5'b00100, 5'b00000);
      check("p2_cnt0", 32'(credit_cnt), 32'(pack(1, 4, 0, 4, 4)));
      check("p2_en0",  32'(credit_en),  32'h1b);
`ifdef CREDIT_BYPASS_EN
      exp_byp = 1'b1;
`else
      exp_byp = 1'b0;
`endif
      flit_sent  = 5'b00100;
      credit_ret = 5'b00100;
      #1;
      check("p2_bypass_en", 32'(credit_en[2]), 32'(exp_byp));
      @(posedge clk);
      #1;
      flit_sent  = '0;
      credit_ret = '0;
      #1;
      check("p2_both_cnt", 32'(credit_cnt), 32'(pack(1, 4, 0, 4, 4)));
      check("p2_both_err", 32'(err),        32'h0);

      // Drain port 1, then underflow port 1 and overflow port 3 together.
      repeat (4) cycle(5'b00010, 5'b00000);
      check("p1_cnt0", 32'(credit_cnt), 32'(pack(1, 0, 0, 4, 4)));
      cycle(5'b00010, 5'b01000);
      check("viol_err",  32'(err),        32'h1);
      check("viol_port", 32'(err_port),   32'h1);
      check("viol_en",   32'(credit_en),  32'h0);
      check("viol_cnt",  32'(credit_cnt), 32'(pack(1, 0, 0, 4, 4)));
      cycle(5'b10001, 5'b00110);
      check("err_frozen", 32'(credit_cnt), 32'(pack(1, 0, 0, 4, 4)));
      check("err_sticky", 32'(err),        32'h1);
      check("err_en",     32'(credit_en),  32'h0);

      // Reset out of ERR.
      rst = 1'b1;
      cycle(5'b00000, 5'b00000);
      check("rerst_err", 32'(err),        32'h0);
      check("rerst_cnt", 32'(credit_cnt), 32'(pack(4, 4, 4, 4, 4)));
      check("rerst_en",  32'(credit_en),  32'h0);
      rst = 1'b0;
      #1;
      check("reinit_en", 32'(credit_en), 32'h0);
      cycle(5'b00000, 5'b00000);
      check("rerun_en", 32'(credit_en), 32'h1f);
      check("rerun_port", 32'(err_port), 32'h0);

      // Legal random traffic against the count model.
      for (int p = 0; p < NP; p++) m[p] = DEPTH;
      for (int k = 0; k < 10000; k++) begin
         for (int p = 0; p < NP; p++) begin
            pick = 2'($urandom_range(0, 3));
            s[p] = pick[0];
            r[p] = pick[1];
            if (s[p] && !r[p] && m[p] == 0)     s[p] = 1'b0;
            if (r[p] && !s[p] && m[p] == DEPTH) r[p] = 1'b0;
            if (s[p] && !r[p]) m[p] = m[p] - 1;
            else if (r[p] && !s[p]) m[p] = m[p] + 1;
         end
         cycle(s, r);
         check("rnd_cnt", 32'(credit_cnt), 32'(pack_model()));
         check("rnd_en",  32'(credit_en),  32'(en_model()));
         check("rnd_err", 32'(err),        32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
